// File: rtl/sw_pulse_gen.sv
// sw_pulse_gen: synchronise, debounce and edge-detect three switches into one-cycle command pulses; optional auto-repeat via SW_AUTOREPEAT_EN
module sw_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] SW,
  output logic       swt_increase,
  output logic       swt_decrease,
  output logic       swt_start_stop,
  output logic [2:0] sw_stable
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  logic [2:0]    r_sync1, r_sync2, r_stable, r_stable_d;
  logic [DW-1:0] r_cnt [3];
  logic [2:0]    w_rise;
  logic [1:0]    w_init, w_rep;
  assign sw_stable = r_stable;
  assign w_rise    = r_stable & ~r_stable_d;
  // a rise is only honoured when the opposite direction is not stable-high
  assign w_init    = {w_rise[1] & ~r_stable[0], w_rise[0] & ~r_stable[1]};
  // two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_sync2, r_sync1} <= '0;
    else {r_sync2, r_sync1} <= {r_sync1, SW};
  // per-channel debounce: stable level flips after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_stable <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (r_sync2[i] == r_stable[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
    end
`ifdef SW_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  typedef enum logic [1:0] {IDLE, WAIT, REPEAT} state_t;
  state_t        r_st [2];
  state_t        w_st_n [2];
  logic [RW-1:0] r_rc [2];
  logic [RW-1:0] w_rc_n [2];
  logic          w_conf;
  assign w_conf = r_stable[0] & r_stable[1];
  // repeat FSM state and counter registers (index 0 increase, 1 decrease)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        r_st[k] <= IDLE;
        r_rc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        r_st[k] <= w_st_n[k];
        r_rc[k] <= w_rc_n[k];
      end
    end
  // repeat FSM next state; release or conflict aborts to IDLE without a pulse
  always_comb
    for (int k = 0; k < 2; k++) begin
      w_st_n[k] = r_st[k];
      w_rc_n[k] = r_rc[k] + 1'b1;
      w_rep[k]  = 1'b0;
      if (!r_stable[k] || w_conf) begin
        w_st_n[k] = IDLE;
        w_rc_n[k] = '0;
      end else
        case (r_st[k])
          IDLE: begin
            w_rc_n[k] = '0;
            w_st_n[k] = w_init[k] ? WAIT : IDLE;
          end
          WAIT:
            if (r_rc[k] == RW'(REPEAT_DELAY - 1)) begin
              w_rep[k]  = 1'b1;
              w_st_n[k] = REPEAT;
              w_rc_n[k] = '0;
            end
          REPEAT:
            if (r_rc[k] == RW'(REPEAT_RATE - 1)) begin
              w_rep[k]  = 1'b1;
              w_rc_n[k] = '0;
            end
          default: begin
            w_st_n[k] = IDLE;
            w_rc_n[k] = '0;
          end
        endcase
    end
`else
  assign w_rep = '0;
`endif
  // registered one-cycle output pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_stable_d     <= '0;
      swt_increase   <= 1'b0;
      swt_decrease   <= 1'b0;
      swt_start_stop <= 1'b0;
    end else begin
      r_stable_d     <= r_stable;
      swt_increase   <= w_init[0] | w_rep[0];
      swt_decrease   <= w_init[1] | w_rep[1];
      swt_start_stop <= w_rise[2];
    end
endmodule

// File: tb/tb_sw_pulse_gen.sv
// tb_sw_pulse_gen: scoreboard bench for sw_pulse_gen with directed switch stimulus
module tb_sw_pulse_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sw  = 3'b000;
  logic       inc, dec, ss;
  logic [2:0] stab;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  typedef struct {int ch; int cyc;} exp_t;
  exp_t       q[$];

  sw_pulse_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8)) dut (
    .clk(clk), .rst(rst), .SW(sw),
    .swt_increase(inc), .swt_decrease(dec), .swt_start_stop(ss),
    .sw_stable(stab)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // a press driven at the negedge of cycle c pulses at cycle c+7; repeats while still stable-high
  task automatic expect_press(input int ch, input int c, input int hold);
    q.push_back('{ch, c + 7});
`ifdef SW_AUTOREPEAT_EN
    if (ch < 2)
      for (int t = c + 27; t <= c + hold + 6; t += 8) q.push_back('{ch, t});
`endif
  endtask

  // monitor: every observed pulse must match the head of the scoreboard
  always @(negedge clk)
    if (!rst)
      for (int k = 0; k < 3; k++)
        if ({ss, dec, inc}[k]) begin
          exp_t e;
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: channel %0d at cycle %0d, none required", k, cyc);
          end else begin
            e = q.pop_front();
            if (e.ch != k || e.cyc != cyc) begin
              n_fail++;
              $display("FAIL pulse_match: got channel %0d cycle %0d, required channel %0d cycle %0d", k, cyc, e.ch, e.cyc);
            end
          end
        end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("reset_stable", stab, 0);
    chk("reset_pulses", {ss, dec, inc}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    // clean press and release of increase
    c = cyc;
    sw[0] = 1'b1;
    expect_press(0, c, 50);
    repeat (5) @(negedge clk);
    chk("t1_stable_before", stab[0], 0);
    @(negedge clk);
    chk("t1_stable_after", stab[0], 1);
    repeat (44) @(negedge clk);
    sw[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("t1_stable_released", stab[0], 0);
    // 3-cycle glitch on decrease must be rejected
    sw[1] = 1'b1;
    repeat (3) @(negedge clk);
    sw[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t2_glitch_stable", stab[1], 0);
      @(negedge clk);
    end
    // long hold of increase (repeats only with auto-repeat)
    c = cyc;
    sw[0] = 1'b1;
    expect_press(0, c, 60);
    repeat (60) @(negedge clk);
    sw[0] = 1'b0;
    repeat (15) @(negedge clk);
    // simultaneous increase/decrease: no pulses, releasing one gives nothing
    sw[1:0] = 2'b11;
    repeat (20) @(negedge clk);
    chk("t4_both_stable", stab, 3'b011);
    sw[1] = 1'b0;
    repeat (15) @(negedge clk);
    chk("t4_one_released", stab, 3'b001);
    sw[0] = 1'b0;
    repeat (15) @(negedge clk);
    // start/stop toggled twice
    c = cyc;
    sw[2] = 1'b1;
    q.push_back('{2, c + 7});
    repeat (10) @(negedge clk);
    sw[2] = 1'b0;
    repeat (10) @(negedge clk);
    sw[2] = 1'b1;
    q.push_back('{2, c + 27});
    repeat (10) @(negedge clk);
    sw[2] = 1'b0;
    repeat (15) @(negedge clk);
    chk("t5_stable_low", stab, 0);
    // reset while holding increase, then re-debounce after release of reset
    c = cyc;
    sw[0] = 1'b1;
    q.push_back('{0, c + 7});
    repeat (15) @(negedge clk);
    chk("t6_stable_before_rst", stab[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_stable", stab, 0);
    chk("t6_rst_pulses", {ss, dec, inc}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c = cyc;
    expect_press(0, c, 40);
    repeat (40) @(negedge clk);
    sw[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
